// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the fp_add_scheduler family of shared-datapath blocks.
// Holds the IEEE-754 single-precision field layout and the in-flight tag format.
package fp_sched_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    // Fixed tag id width so the tag type can live here; covers up to 8 requesters.
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mantissa;
    } fp32_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam logic [FP_W-1:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 32'h4040_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer (wrapping),
// and moves the pointer just past the winner whenever the grant is consumed.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  pointer
);

    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        // Walk from farthest to nearest so the requester closest to the pointer wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(pointer) + k) % NREQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pointer <= '0;
        end else if (advance) begin
            pointer <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Time-shares one pipelined fp32 add/sub unit between NREQ requesters and routes each
// result back to its originator through a tag pipeline matched to the adder latency.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int ADD_LAT = 2,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_command,
    input  logic [FP_W*NREQ-1:0] req_number1,
    input  logic [FP_W*NREQ-1:0] req_number2,
    output logic                 add_command,
    output logic [FP_W-1:0]      add_number1,
    output logic [FP_W-1:0]      add_number2,
    input  logic [FP_W-1:0]      add_sum,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_data,
    output logic                 busy
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  rr_pointer;
    logic            accept;

    assign req_ready = grant & {NREQ{enable}};
    assign accept    = |req_ready;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .pointer (rr_pointer)
    );

    // Operand select for the granted requester.
    logic  sel_cmd;
    fp32_t sel_num1;
    fp32_t sel_num2;

    always_comb begin
        sel_cmd  = 1'b0;
        sel_num1 = '0;
        sel_num2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_cmd  = req_command[i];
                sel_num1 = req_number1[FP_W*i +: FP_W];
                sel_num2 = req_number2[FP_W*i +: FP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            add_command <= 1'b0;
            add_number1 <= '0;
            add_number2 <= '0;
        end else if (accept) begin
            add_command <= sel_cmd;
            add_number1 <= sel_num1;
            add_number2 <= sel_num2;
        end
    end

    // Stage 0: the pointer already moved to winner+1 on the accept edge, so the
    // issued id is recovered from it rather than re-encoding the grant.
    logic           issue_q;
    logic [IDW-1:0] issued_idx;
    tag_t           tag0;
    tag_t           tag_q [1:ADD_LAT];
    tag_t           tag_last;

    assign issued_idx = (rr_pointer == '0) ? IDW'(NREQ - 1) : rr_pointer - IDW'(1);
    assign tag0       = '{valid: issue_q, id: TAG_IDW'(issued_idx)};
    assign tag_last   = tag_q[ADD_LAT];

    // NOTE: the tag stages are a small array but carry valid bits, so each entry is
    // reset; otherwise a reset mid-stream could replay stale responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_q <= 1'b0;
            for (int s = 1; s <= ADD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            issue_q  <= accept;
            tag_q[1] <= tag0;
            for (int s = 2; s <= ADD_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    logic [NREQ-1:0] rsp_onehot;

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag_last.id == TAG_IDW'(i)) begin
                rsp_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_last.valid ? rsp_onehot : '0;
            if (tag_last.valid) begin
                rsp_data <= add_sum;
            end
        end
    end

    // Activity tracker: RUN while any tag stage or the response register is occupied.
    sched_state_t state;
    sched_state_t next_state;
    logic         any_inflight;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        any_inflight = issue_q;
        for (int s = 1; s <= ADD_LAT; s++) begin
            any_inflight = any_inflight | tag_q[s].valid;
        end
        next_state = (accept || any_inflight) ? RUN : IDLE;
    end

    always_comb begin
        busy = (state == RUN);
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level arbitration/latency model.
module tb_fp_add_scheduler;
    import fp_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int ADD_LAT = 2;
    localparam int LAT     = ADD_LAT + 2;

    logic                 clk;
    logic                 rstn;
    logic                 enable;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_command;
    logic [FP_W*NREQ-1:0] req_number1;
    logic [FP_W*NREQ-1:0] req_number2;
    logic                 add_command;
    logic [FP_W-1:0]      add_number1;
    logic [FP_W-1:0]      add_number2;
    logic [FP_W-1:0]      add_sum;
    logic [NREQ-1:0]      rsp_valid;
    logic [FP_W-1:0]      rsp_data;
    logic                 busy;

    fp_add_scheduler #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_command (req_command),
        .req_number1 (req_number1),
        .req_number2 (req_number2),
        .add_command (add_command),
        .add_number1 (add_number1),
        .add_number2 (add_number2),
        .add_sum     (add_sum),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fp32 <-> real conversions, exact for normal values and zero.
    function automatic real fp_to_real(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        return real_to_fp($itor(v));
    endfunction

    // Behavioural adder: ADD_LAT register stages after the sampling edge.
    logic [31:0] adder_p1, adder_p2;
    always_ff @(posedge clk) begin
        adder_p1 <= real_to_fp(add_command ? fp_to_real(add_number1) - fp_to_real(add_number2)
                                           : fp_to_real(add_number1) + fp_to_real(add_number2));
        adder_p2 <= adder_p1;
    end
    assign add_sum = adder_p2;

    typedef struct packed {
        logic        cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } job_t;

    typedef struct packed {
        int          cyc;
        logic [7:0]  id;
        logic [31:0] data;
    } ev_t;

    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;
    job_t            jobq [NREQ][$];
    job_t            cur [NREQ];
    logic [NREQ-1:0] pend_valid;
    logic [NREQ-1:0] acc_flag;
    int              mptr;
    ev_t             sbq[$];
    ev_t             acc_log[$];
    ev_t             rsp_log[$];
    logic [31:0]     last_data;
    int              busy_last_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic job_t make_job(input logic cmd, input int ia, input int ib);
        job_t j;
        j.cmd = cmd;
        j.a   = int_to_fp(ia);
        j.b   = int_to_fp(ib);
        j.res = int_to_fp(cmd ? ia - ib : ia + ib);
        return j;
    endfunction

    function automatic int rnd_int();
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, evaluated mid-cycle while inputs are stable.
    logic [NREQ-1:0] m_exp_ready;
    logic [NREQ-1:0] m_exp_rv;
    logic            m_found;
    logic            m_exp_busy;
    int              m_idx;
    ev_t             m_ev;

    always @(negedge clk) begin
        if (!rstn) begin
            sbq.delete();
            mptr      = 0;
            acc_flag  = '0;
            last_data = '0;
        end else begin
            m_exp_busy = (sbq.size() > 0) && (sbq[0].cyc - LAT < cyc);
            check("busy", 32'(busy), 32'(m_exp_busy));
            if (busy) busy_last_hi = cyc;

            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                m_ev     = sbq.pop_front();
                m_exp_rv = NREQ'(1) << m_ev.id;
                check("rsp_valid", 32'(rsp_valid), 32'(m_exp_rv));
                check("rsp_data", rsp_data, m_ev.data);
                last_data = m_ev.data;
                rsp_log.push_back('{cyc, m_ev.id, rsp_data});
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                check("rsp_data_hold", rsp_data, last_data);
                if (rsp_valid != '0) rsp_log.push_back('{cyc, 8'hFF, rsp_data});
            end

            m_exp_ready = '0;
            m_found     = 1'b0;
            m_idx       = 0;
            if (enable) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!m_found && req_valid[(mptr + k) % NREQ]) begin
                        m_found = 1'b1;
                        m_idx   = (mptr + k) % NREQ;
                    end
                end
            end
            if (m_found) m_exp_ready[m_idx] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(m_exp_ready));
            if (m_found) begin
                sbq.push_back('{cyc + LAT, 8'(m_idx), cur[m_idx].res});
                acc_log.push_back('{cyc, 8'(m_idx), cur[m_idx].res});
                acc_flag[m_idx] = 1'b1;
                mptr = (m_idx + 1) % NREQ;
            end
        end
    end

    task automatic drive();
        req_valid = pend_valid;
        for (int i = 0; i < NREQ; i++) begin
            req_command[i]           = cur[i].cmd;
            req_number1[32*i +: 32]  = cur[i].a;
            req_number2[32*i +: 32]  = cur[i].b;
        end
    endtask

    // One clock: retire accepted requests, present the next queued job per requester.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_flag[i]) begin
                pend_valid[i] = 1'b0;
                acc_flag[i]   = 1'b0;
            end
            if (!pend_valid[i] && jobq[i].size() > 0) begin
                cur[i]        = jobq[i].pop_front();
                pend_valid[i] = 1'b1;
            end
        end
        drive();
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (pend_valid == '0) && (sbq.size() == 0);
        for (int i = 0; i < NREQ; i++) if (jobq[i].size() > 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input string tag, input int budget);
        bit done;
        done   = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (all_idle()) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check(tag, 32'(done), 32'd1);
        step();
        step();
    endtask

    task automatic clear_logs();
        acc_log.delete();
        rsp_log.delete();
    endtask

    initial begin
        int exp_order [5];
        bit got3;
        exp_order   = '{0, 1, 2, 3, 0};
        rstn        = 1'b0;
        enable      = 1'b0;
        pend_valid  = '0;
        acc_flag    = '0;
        for (int i = 0; i < NREQ; i++) cur[i] = '0;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_cmd", 32'(add_command), 32'd0);
        check("rst_add_n1", add_number1, 32'd0);
        check("rst_add_n2", add_number2, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single requester 0: 1.0 + 2.0.
        enable = 1'b1;
        clear_logs();
        jobq[0].push_back('{1'b0, FP_ONE, FP_TWO, FP_THREE});
        drain("a_drain", 60);
        check("a_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() > 0 && acc_log.size() > 0) begin
            check("a_rsp_id", 32'(rsp_log[0].id), 32'd0);
            check("a_latency", rsp_log[0].cyc - acc_log[0].cyc, LAT);
            check("a_rsp_data", rsp_log[0].data, FP_THREE);
        end

        // Requester 2 alone: 3.0 - 1.0.
        clear_logs();
        jobq[2].push_back('{1'b1, FP_THREE, FP_ONE, FP_TWO});
        drain("b_drain", 60);
        check("b_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() > 0) begin
            check("b_rsp_id", 32'(rsp_log[0].id), 32'd2);
            check("b_rsp_data", rsp_log[0].data, FP_TWO);
        end

        // Reset with three operations in flight.
        clear_logs();
        for (int i = 1; i < NREQ; i++) jobq[i].push_back(make_job(1'b0, rnd_int(), rnd_int()));
        got3 = 1'b0;
        for (int k = 0; k < 20 && !got3; k++) begin
            step();
            got3 = (acc_log.size() >= 3);
        end
        check("r_three_issued", 32'(got3), 32'd1);
        rstn       = 1'b0;
        pend_valid = '0;
        for (int i = 0; i < NREQ; i++) jobq[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("r_busy_after", 32'(busy), 32'd0);
        check("r_add_n1_after", add_number1, 32'd0);
        rsp_log.delete();
        repeat (8) step();
        check("r_no_rsp", rsp_log.size(), 0);

        // All four requesters valid: strict rotation from pointer 0.
        clear_logs();
        jobq[0].push_back(make_job(1'b0, 10, 20));
        for (int i = 1; i < NREQ; i++) jobq[i].push_back(make_job(1'b1, 100 * i, 7 * i));
        jobq[0].push_back(make_job(1'b1, -5, 12));
        drain("c_drain", 80);
        check("c_acc_count", acc_log.size(), 5);
        check("c_rsp_count", rsp_log.size(), 5);
        if (acc_log.size() == 5 && rsp_log.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("c_acc_order", 32'(acc_log[k].id), 32'(exp_order[k]));
                check("c_acc_cycle", acc_log[k].cyc - acc_log[0].cyc, k);
                check("c_rsp_order", 32'(rsp_log[k].id), 32'(exp_order[k]));
            end
        end

        // Requesters 1 and 3, enable dropped after two accepts.
        clear_logs();
        for (int n = 0; n < 3; n++) begin
            jobq[1].push_back(make_job(1'b0, rnd_int(), rnd_int()));
            jobq[3].push_back(make_job(1'b1, rnd_int(), rnd_int()));
        end
        for (int k = 0; k < 20 && acc_log.size() < 2; k++) step();
        enable = 1'b0;
        repeat (10) step();
        check("d_acc_count", acc_log.size(), 2);
        check("d_rsp_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("d_rsp_first", 32'(rsp_log[0].id), 32'd1);
            check("d_rsp_second", 32'(rsp_log[1].id), 32'd3);
            check("d_busy_fall", busy_last_hi, rsp_log[1].cyc);
        end
        drain("d_drain", 80);

        // Single requester back-to-back: granted every cycle, ADD_LAT+1 in flight.
        clear_logs();
        for (int n = 0; n < 4; n++) jobq[2].push_back(make_job(n[0], rnd_int(), rnd_int()));
        drain("e_drain", 60);
        check("e_acc_count", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            for (int k = 1; k < 4; k++) check("e_back_to_back", acc_log[k].cyc - acc_log[0].cyc, k);
        end

        // Random traffic with random enable gaps.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (jobq[i].size() < 2 && $urandom_range(0, 3) == 0)
                    jobq[i].push_back(make_job(1'($urandom_range(0, 1)), rnd_int(), rnd_int()));
            end
            enable = ($urandom_range(0, 9) != 0);
            step();
        end
        drain("rand_drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
- Shares one single-precision IEEE-754 add/sub unit between NREQ requesters.
- Round-robin arbitration accepts at most one operation per cycle and drives the adder's operand/command inputs from registers.
- Tracks each issued operation's requester ID through a tag pipeline matched to the adder latency.
- Returns each result to the originating requester as a one-cycle response pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 2, cycles from the adder sampling its inputs to a valid result on its outputs.
- IDW, $clog2(NREQ), requester-ID width (derived, not overridable).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new grants; in-flight operations still complete.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  one-hot or zero; requester i's operation accepted this cycle.
- req_command  in  NREQ  per requester: 0 = add, 1 = subtract (number1 - number2).
- req_number1  in  32*NREQ  flattened operand A, slice i at [32*i +: 32].
- req_number2  in  32*NREQ  flattened operand B, same slicing.
- add_command  out  1  to adder, registered.
- add_number1  out  32  to adder, registered.
- add_number2  out  32  to adder, registered.
- add_sum  in  32  adder result, {sign, exponent[7:0], mantissa[22:0]}.
- rsp_valid  out  NREQ  one-hot pulse; result for requester i is on rsp_data.
- rsp_data  out  32  registered copy of add_sum for the responding requester.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (async assert, sync deassert):
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - add_command=0, add_number1=0, add_number2=0.
  - Round-robin pointer=0; all tag-pipeline stages invalid.
- Arbitration (combinational):
  - Search from pointer upward, modulo NREQ, for the first i with req_valid[i]=1.
  - grant = one-hot of that i; req_ready = grant & {NREQ{enable}}.
  - Handshake: req_valid & req_ready in the same cycle = accepted.
  - Requester must hold req_valid and operands stable until accepted.
- Issue (registered, on accept):
  - add_command/add_number1/add_number2 <= granted requester's slice.
  - tag stage 0 <= {valid=1, id=i}.
  - Pointer <= (i+1) mod NREQ.
  - Pointer is unchanged when nothing is accepted.
  - Operand registers hold their last value when idle; the adder may recompute them, and the tag pipeline marks that as don't-care.
- Tag pipeline:
  - ADD_LAT+1 stages shift every cycle, no stalls. Stage 0 aligns with the operand registers; the last stage aligns with add_sum validity.
  - When the last stage is valid: next cycle rsp_valid[id]=1 for exactly one cycle and rsp_data <= add_sum.
  - Otherwise rsp_valid=0 and rsp_data holds its last value.
- Latency: accept cycle T -> rsp_valid at T+ADD_LAT+2. Sustained throughput is 1 op/cycle.
- No response backpressure: requesters must always sink rsp_valid.
- busy = OR of all tag-stage valids OR any rsp_valid.
- States: IDLE (busy=0), RUN (busy=1). RUN -> IDLE when the last response issues and no new accept occurs that cycle. busy is a registered function of the tag valids.
- Boundary conditions:
  - All requesters valid: strict rotation 0,1,2,3,0...; each gets 1 of NREQ slots.
  - Single requester valid: granted every cycle.
  - enable deasserted mid-stream: accepts stop the same cycle; outstanding results still return; pointer frozen.
  - Reset mid-operation: all in-flight tags dropped; no spurious rsp_valid after rstn rises.
  - The same requester may have up to ADD_LAT+1 operations in flight. Responses return in issue order.

Decomposition:
- Package fp_sched_pkg:
  - FP_W=32, EXP_W=8, MAN_W=23.
  - typedef fp32_t as a packed struct {sign, exponent, mantissa}.
  - typedef tag_t as a packed struct {valid, id[IDW-1:0]}.
  - Constants FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_THREE=32'h40400000.
- Sub-module rr_arbiter (NREQ): inputs req, advance, rstn, clk; outputs grant and pointer. Reused by later shared-datapath blocks.

Test Plan:
- Reset mid-stream with 3 ops in flight -> no rsp_valid after release; busy=0; add_number1=0.
- Single requester 0, add 1.0+2.0 (0x3F800000, 0x40000000, cmd=0), accepted cycle T -> rsp_valid=4'b0001 at T+4, rsp_data=0x40400000 (ADD_LAT=2 behavioural adder model).
- All four valid, each holding a distinct operation -> accept order 0,1,2,3,0 on consecutive cycles; responses in the same order, one per cycle, each carrying the correct sum.
- Requester 2 only, subtract 3.0-1.0 (cmd=1) -> rsp_valid=4'b0100, rsp_data=0x40000000.
- Requesters 1 and 3 valid, enable dropped after 2 accepts -> exactly 2 responses (1 then 3); req_ready=0 while enable=0; busy falls 1 cycle after the last rsp_valid.
